// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline stage register.
//
// Payload is split into a DATA field (kept on flush, useful for debug) and a
// CTRL field (cleared on flush, so a flushed stage emits a NOP bubble).
// SKID=0 gives a single head register with a combinational in_ready.
// SKID=1 adds a second skid entry so in_ready comes straight from a flop.
//
// Optional feature macro: PIPE_STAGE_STATS_EN
//   defined   -> stall_cnt is a saturating count of out_valid & !out_ready cycles
//   undefined -> stall_cnt is tied to zero
//
// Ports:
//   clk        stage clock
//   reset      asynchronous, active-high reset
//   flush      kill all held entries and any input accepted this cycle
//   in_valid   upstream has an entry
//   in_ready   stage can accept an entry
//   in_data    upstream data payload (DATA_W)
//   in_ctrl    upstream control payload (CTRL_W)
//   out_valid  head entry is valid
//   out_ready  downstream accepts the head entry
//   out_data   head data payload (DATA_W)
//   out_ctrl   head control payload, zero whenever out_valid=0 (CTRL_W)
//   occupancy  number of valid entries held (0..2)
//   stall_cnt  stalled-cycle counter (32 bits)
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt
);

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic              push, pop;

  assign push = in_valid & in_ready;
  assign pop  = head_valid_q & out_ready;

  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;
  // head_ctrl_q is cleared whenever the head goes invalid, so no masking needed.
  assign out_ctrl  = head_ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_ctrl_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_ctrl_q  <= head_ctrl_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic              skb_valid_q, skb_valid_d;
    logic [DATA_W-1:0] skb_data_q, skb_data_d;
    logic [CTRL_W-1:0] skb_ctrl_q, skb_ctrl_d;

    // Registered ready: the stage can always absorb one more entry unless the
    // skid slot is already occupied.
    assign in_ready  = ~skb_valid_q;
    assign occupancy = {1'b0, head_valid_q} + {1'b0, skb_valid_q};

    always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      head_ctrl_d  = head_ctrl_q;
      skb_valid_d  = skb_valid_q;
      skb_data_d   = skb_data_q;
      skb_ctrl_d   = skb_ctrl_q;
      if (flush) begin
        head_valid_d = 1'b0;
        head_ctrl_d  = '0;
        skb_valid_d  = 1'b0;
        skb_ctrl_d   = '0;
        // Data is captured regardless of in_ready so the killed entry stays visible.
        if (in_valid) begin
          head_data_d = in_data;
        end
      end else if (pop && skb_valid_q) begin
        // Skid entry advances; a concurrent accept refills the skid slot.
        head_valid_d = 1'b1;
        head_data_d  = skb_data_q;
        head_ctrl_d  = skb_ctrl_q;
        skb_valid_d  = push;
        if (push) begin
          skb_data_d = in_data;
          skb_ctrl_d = in_ctrl;
        end else begin
          skb_ctrl_d = '0;
        end
      end else if (push && (!head_valid_q || pop)) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
        head_ctrl_d  = in_ctrl;
      end else if (push) begin
        skb_valid_d = 1'b1;
        skb_data_d  = in_data;
        skb_ctrl_d  = in_ctrl;
      end else if (pop) begin
        head_valid_d = 1'b0;
        head_ctrl_d  = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        skb_valid_q <= 1'b0;
        skb_data_q  <= '0;
        skb_ctrl_q  <= '0;
      end else begin
        skb_valid_q <= skb_valid_d;
        skb_data_q  <= skb_data_d;
        skb_ctrl_q  <= skb_ctrl_d;
      end
    end
  end else begin : g_single
    assign in_ready  = ~head_valid_q | out_ready;
    assign occupancy = {1'b0, head_valid_q};

    always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      head_ctrl_d  = head_ctrl_q;
      if (flush) begin
        head_valid_d = 1'b0;
        head_ctrl_d  = '0;
        if (in_valid) begin
          head_data_d = in_data;
        end
      end else if (push) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
        head_ctrl_d  = in_ctrl;
      end else if (pop) begin
        head_valid_d = 1'b0;
        head_ctrl_d  = '0;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_q;

  // Saturating; deliberately not cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (head_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
